// File: rtl/mul_pkg.sv
// mul_pkg: shared types and frame-geometry helpers for the product unloader.
// UNLOADER_SIGN_EN adds the multiplier sign bit as the top frame bit.
package mul_pkg;
  typedef enum logic {IDLE, SEND} state_t;
`ifdef UNLOADER_SIGN_EN
  localparam int SIGN_W = 1;
`else
  localparam int SIGN_W = 0;
`endif
  function automatic int frame_w(input int p_width);
    return p_width + SIGN_W;
  endfunction
  function automatic int beats(input int fw, input int ow);
    return (fw + ow - 1) / ow;
  endfunction
  function automatic int beat_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mul_product_fifo.sv
// mul_product_fifo: two-entry product buffer with registered full/empty and head.
module mul_product_fifo
  import mul_pkg::*;
#(
  parameter int W     = 4,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  logic [W-1:0] mem [2];
  logic         wr_ptr, rd_ptr, do_push, do_pop;
  logic [1:0]   count;
  assign full    = count == 2'(DEPTH);
  assign empty   = count == 2'd0;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      wr_ptr <= wr_ptr ^ do_push;
      rd_ptr <= rd_ptr ^ do_pop;
      count  <= count + 2'(do_push) - 2'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/mul_product_unloader.sv
// mul_product_unloader: buffers multiplier products and streams them out LSB slice first.
// Define UNLOADER_SIGN_EN to carry in_s as the top frame bit.
module mul_product_unloader
  import mul_pkg::*;
#(
  parameter int P_WIDTH   = 4,
  parameter int OUT_WIDTH = 2,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [P_WIDTH-1:0]   in_p,
  input  logic                 in_s,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ack,
  output logic                 ovf
);
  localparam int FW    = frame_w(P_WIDTH);
  localparam int BEATS = beats(FW, OUT_WIDTH);
  localparam int BW    = beat_w(BEATS);
  localparam int FLEN  = BEATS * OUT_WIDTH;
  state_t          state;
  logic [BW-1:0]   beat;
  logic [FW-1:0]   din, head;
  logic [FLEN-1:0] frame;
  logic            full, empty, push, pop, last;
`ifdef UNLOADER_SIGN_EN
  assign din = {in_s, in_p};
`else
  logic unused_s;
  assign unused_s = in_s;
  assign din      = in_p;
`endif
  assign in_ready  = !full;
  assign push      = in_valid && !full;
  assign last      = beat == BW'(BEATS - 1);
  assign pop       = out_valid && out_ack && last;
  assign frame     = FLEN'(head);
  assign out_valid = state == SEND;
  assign out_last  = out_valid && last;
  assign out_data  = out_valid ? frame[beat*OUT_WIDTH +: OUT_WIDTH] : '0;
  mul_product_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .full  (full),
    .empty (empty),
    .head  (head)
  );
  // SEND exactly while the buffer will hold a frame after this edge, so frames chain without bubbles
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      beat  <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= (push || (!empty && (!pop || full))) ? SEND : IDLE;
      ovf   <= ovf | (in_valid && full);
      if (out_valid && out_ack) beat <= last ? '0 : beat + BW'(1);
    end
endmodule

// File: tb/tb_mul_product_unloader.sv
// tb_mul_product_unloader: directed and random checks against a queue-based frame model.
module tb_mul_product_unloader;
`ifdef UNLOADER_SIGN_EN
  localparam int FW = 5;
`else
  localparam int FW = 4;
`endif
  localparam int BEATS = (FW + 1) / 2;
  logic       clk = 0, rst = 0, in_s = 0, in_valid = 0, out_ack = 0;
  logic [3:0] in_p = 0;
  logic [1:0] out_data;
  logic       in_ready, out_valid, out_last, ovf;
  int checks = 0, failures = 0;
  int q[$];
  int mbeat = 0, sz = 0;
  bit m_ovf = 0;

  mul_product_unloader dut (
    .clk(clk), .rst(rst), .in_p(in_p), .in_s(in_s), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_ack(out_ack), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", n, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] p, input logic s, input logic a);
    in_valid = v; in_p = p; in_s = s; out_ack = a;
  endtask

  // reference: a queue of whole frames plus the index of the beat on show
  always @(posedge clk or negedge rst)
    if (!rst) begin
      q.delete(); mbeat = 0; m_ovf = 0;
    end else begin
      sz = q.size();
      if (sz > 0 && out_ack) begin
        if (mbeat == BEATS - 1) begin void'(q.pop_front()); mbeat = 0; end
        else mbeat++;
      end
      if (in_valid) begin
        if (sz < 2) q.push_back(FW == 5 ? {27'd0, in_s, in_p} : {28'd0, in_p});
        else m_ovf = 1;
      end
    end

  always @(negedge clk) begin
    chk("m_valid", out_valid, q.size() > 0);
    chk("m_data", out_data, q.size() > 0 ? (q[0] >> (2 * mbeat)) & 3 : 0);
    chk("m_last", out_last, q.size() > 0 && mbeat == BEATS - 1);
    chk("m_ready", in_ready, q.size() < 2);
    chk("m_ovf", ovf, m_ovf);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0); chk("rst_ready", in_ready, 1);
    chk("rst_data", out_data, 0); chk("rst_ovf", ovf, 0);
    rst = 1;
    @(negedge clk);
`ifdef UNLOADER_SIGN_EN
    drive(1, 4'b0110, 1, 1);
    @(negedge clk); drive(0, 0, 0, 1);
    chk("sg_b0", out_data, 2); chk("sg_l0", out_last, 0);
    @(negedge clk); chk("sg_b1", out_data, 1); chk("sg_l1", out_last, 0);
    @(negedge clk); chk("sg_b2", out_data, 1); chk("sg_l2", out_last, 1);
    @(negedge clk); chk("sg_idle", out_valid, 0);
`else
    drive(1, 4'b1001, 0, 1);
    @(negedge clk); drive(0, 0, 0, 1);
    chk("sf_b0", out_data, 1); chk("sf_l0", out_last, 0);
    @(negedge clk); chk("sf_b1", out_data, 2); chk("sf_l1", out_last, 1);
    @(negedge clk); chk("sf_idle", out_valid, 0);
`endif
    drive(1, 4'h3, 0, 0);
    @(negedge clk); drive(1, 4'hC, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0);
    repeat (10) @(negedge clk);
    chk("bp_ready", in_ready, 0); chk("bp_data", out_data, 3);
    drive(1, 4'h7, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0);
    chk("bp_ovf", ovf, 1);
    drive(0, 0, 0, 1);
    repeat (8) @(negedge clk);
    chk("bp_drained", out_valid, 0); chk("bp_ovf_sticky", ovf, 1);
    drive(1, 4'h9, 0, 0);
    @(negedge clk); drive(0, 0, 0, 1);
    @(negedge clk);
    #2 rst = 0;
    #1;
    chk("ar_valid", out_valid, 0); chk("ar_data", out_data, 0); chk("ar_last", out_last, 0);
    chk("ar_ready", in_ready, 1); chk("ar_ovf", ovf, 0);
    @(negedge clk); rst = 1; drive(0, 0, 0, 0);
    @(negedge clk); chk("ar_post_ready", in_ready, 1); chk("ar_post_valid", out_valid, 0);
    drive(1, 4'h1, 0, 1);
    @(negedge clk); drive(0, 0, 0, 1);
    for (int i = 0; i < 8 && !out_last; i++) @(negedge clk);
    chk("sp_last", out_last, 1);
    drive(1, 4'h5, 0, 1);
    @(negedge clk); drive(0, 0, 0, 1);
    chk("sp_valid", out_valid, 1); chk("sp_b0", out_data, 1);
    @(negedge clk); chk("sp_b1", out_data, 1);
    repeat (4) @(negedge clk);
    drive(0, 0, 0, 1);
    repeat (3) @(negedge clk);
    drive(1, 4'hA, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0);
    chk("na_valid", out_valid, 1); chk("na_b0", out_data, 2);
    drive(0, 0, 0, 1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 2) == 0, 4'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 400) == 0) begin
        #2 rst = 0;
        @(negedge clk); rst = 1;
      end else @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
